// File: rtl/video_pkg.sv
// Shared types for the video timing detector: lock FSM states and frame geometry.
package video_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } vtd_state_e;

  // Wide enough for any supported raster; narrower counts are zero-extended.
  localparam int GEOM_W = 16;

  typedef struct packed {
    logic [GEOM_W-1:0] width;
    logic [GEOM_W-1:0] height;
  } geom_t;

  localparam logic VS_POL_DEFAULT = 1'b1;

endpackage

// File: rtl/video_timing_detector_if.sv
// Video stream bundle: raw DE/HSYNC/VSYNC in, recovered raster position and geometry out.
interface video_timing_detector_if #(
  parameter int HLEN = 10,
  parameter int VLEN = 10
);

  logic            i_de;
  logic            i_hsync;
  logic            i_vsync;
  logic            o_de;
  logic            o_hsync;  // registered hsync, aligned with o_de
  logic [HLEN-1:0] o_hcount;
  logic [VLEN-1:0] o_vcount;
  logic [HLEN:0]   o_hactive;
  logic [VLEN:0]   o_vactive;
  logic            o_frame_start;
  logic            o_frame_end;
  logic            o_locked;
  logic            o_err;

  modport master (
    output i_de, i_hsync, i_vsync,
    input  o_de, o_hsync, o_hcount, o_vcount, o_hactive, o_vactive,
    input  o_frame_start, o_frame_end, o_locked, o_err
  );

  modport slave (
    input  i_de, i_hsync, i_vsync,
    output o_de, o_hsync, o_hcount, o_vcount, o_hactive, o_vactive,
    output o_frame_start, o_frame_end, o_locked, o_err
  );

endinterface

// File: rtl/video_timing_detector_sync.sv
// Registers one input bit and flags rising/falling transitions of the registered copy.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  // NOTE: non-blocking assignments so q_d captures the old q on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/video_timing_detector.sv
// Recovers active-area position from a DE/VSYNC stream, measures frame geometry
// and declares lock after LOCK_FRAMES consecutive identical good frames.
module video_timing_detector
  import video_pkg::*;
#(
  parameter int   HMAX        = 800,
  parameter int   VMAX        = 600,
  parameter int   HLEN        = $clog2(HMAX),
  parameter int   VLEN        = $clog2(VMAX),
  parameter int   LOCK_FRAMES = 3,
  parameter logic VS_POL      = VS_POL_DEFAULT
) (
  input logic clk,
  input logic rst,
  video_timing_detector_if.slave vid
);

  localparam int HW = HLEN + 1;
  localparam int VW = VLEN + 1;
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  // Counters run one past the last index so a full-width line measures as HMAX.
  localparam logic [HW-1:0]   HSAT     = HW'(HMAX);
  localparam logic [VW-1:0]   VSAT     = VW'(VMAX);
  localparam logic [HLEN-1:0] HIDX_MAX = HLEN'(HMAX - 1);
  localparam logic [VLEN-1:0] VIDX_MAX = VLEN'(VMAX - 1);

  logic de_q, de_rise, de_fall;
  logic vs_q, vs_rise, vs_fall;
  logic hs_q;

  sync_edge_detect u_de_sync (
    .clk (clk),
    .rst (rst),
    .d   (vid.i_de),
    .q   (de_q),
    .rise(de_rise),
    .fall(de_fall)
  );

  sync_edge_detect u_vs_sync (
    .clk (clk),
    .rst (rst),
    .d   (vid.i_vsync),
    .q   (vs_q),
    .rise(vs_rise),
    .fall(vs_fall)
  );

  logic [HW-1:0] pix_cnt, ref_width, ref_w_eff;
  logic [VW-1:0] line_cnt, lines_next;
  logic          frame_bad, skip_line, fs_armed, err;
  logic          vs_edge, count_px, line_fall, mid_line, line_done;
  logic          pix_ovf, line_ovf, width_err, bad_now, err_now;
  logic          frame_valid, frame_good;
  geom_t         cand;

  assign vs_edge   = VS_POL ? vs_rise : vs_fall;
  // After a mid-line vsync the rest of that line belongs to no frame.
  assign count_px  = de_q & ~skip_line;
  assign line_fall = de_fall & ~skip_line;
  assign mid_line  = vs_edge & de_q & ~skip_line;
  assign line_done = line_fall | mid_line;

  assign pix_ovf    = count_px & (pix_cnt == HSAT);
  assign line_ovf   = line_done & (line_cnt == VSAT);
  assign width_err  = line_fall & (line_cnt != '0) & (pix_cnt != ref_width);
  assign err_now    = pix_ovf | line_ovf | width_err;
  assign bad_now    = frame_bad | err_now | mid_line;
  assign lines_next = (line_done && line_cnt != VSAT) ? line_cnt + VW'(1) : line_cnt;
  assign ref_w_eff  = (line_fall && line_cnt == '0) ? pix_cnt : ref_width;

  assign frame_valid = vs_edge & (lines_next != '0);
  assign frame_good  = frame_valid & ~bad_now;
  assign cand        = '{width: GEOM_W'(ref_w_eff), height: GEOM_W'(lines_next)};

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      ref_width <= '0;
      frame_bad <= 1'b0;
      skip_line <= 1'b0;
      fs_armed  <= 1'b1;
      err       <= 1'b0;
      hs_q      <= 1'b0;
    end else begin
      hs_q <= vid.i_hsync;
      if (err_now) err <= 1'b1;
      if (vs_edge) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        frame_bad <= 1'b0;
        skip_line <= de_q;
        fs_armed  <= 1'b1;
      end else begin
        if (de_fall) begin
          pix_cnt   <= '0;
          skip_line <= 1'b0;
        end else if (count_px && pix_cnt != HSAT) begin
          pix_cnt <= pix_cnt + HW'(1);
        end
        if (line_fall) begin
          line_cnt <= lines_next;
          if (line_cnt == '0) ref_width <= pix_cnt;
        end
        if (bad_now) frame_bad <= 1'b1;
        if (de_rise) fs_armed <= 1'b0;
      end
    end
  end

  vtd_state_e    state, state_n;
  geom_t         geo, geo_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [HW-1:0] hactive;
  logic [VW-1:0] vactive;
  logic          load_active;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n     = state;
    geo_n       = geo;
    match_n     = match_cnt;
    load_active = 1'b0;
    if (frame_valid) begin
      unique case (state)
        SEARCH: begin
          if (frame_good) begin
            geo_n   = cand;
            match_n = MW'(1);
            if (LOCK_FRAMES == 1) begin
              state_n     = LOCKED;
              load_active = 1'b1;
            end else begin
              state_n = ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (!frame_good) begin
            state_n = SEARCH;
          end else if (cand == geo) begin
            match_n = match_cnt + MW'(1);
            if (int'(match_cnt) + 1 >= LOCK_FRAMES) begin
              state_n     = LOCKED;
              load_active = 1'b1;
            end
          end else begin
            geo_n   = cand;
            match_n = MW'(1);
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_n = SEARCH;
          end else if (cand != geo) begin
            // The new geometry already counts as the first match of a fresh acquire.
            geo_n   = cand;
            match_n = MW'(1);
            state_n = ACQUIRE;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      geo       <= '0;
      match_cnt <= '0;
      hactive   <= '0;
      vactive   <= '0;
    end else begin
      state     <= state_n;
      geo       <= geo_n;
      match_cnt <= match_n;
      if (load_active) begin
        hactive <= cand.width[HW-1:0];
        vactive <= cand.height[VW-1:0];
      end
    end
  end

  assign vid.o_de          = de_q;
  assign vid.o_hsync       = hs_q;
  assign vid.o_hcount      = !de_q ? '0 : (pix_cnt >= HSAT) ? HIDX_MAX : pix_cnt[HLEN-1:0];
  assign vid.o_vcount      = !de_q ? '0 : (line_cnt >= VSAT) ? VIDX_MAX : line_cnt[VLEN-1:0];
  assign vid.o_hactive     = hactive;
  assign vid.o_vactive     = vactive;
  assign vid.o_frame_start = de_rise & fs_armed & ~vs_edge;
  assign vid.o_frame_end   = vs_edge;
  assign vid.o_locked      = (state == LOCKED);
  assign vid.o_err         = err;

endmodule

// File: tb/tb_video_timing_detector.sv
// Directed bench for video_timing_detector with HMAX=16, VMAX=12, LOCK_FRAMES=3.
module tb_video_timing_detector;

  localparam int HMAX        = 16;
  localparam int VMAX        = 12;
  localparam int HLEN        = 4;
  localparam int VLEN        = 4;
  localparam int LOCK_FRAMES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   fs_cnt   = 0;

  always #5 clk = ~clk;

  video_timing_detector_if #(.HLEN(HLEN), .VLEN(VLEN)) vid ();

  video_timing_detector #(
    .HMAX       (HMAX),
    .VMAX       (VMAX),
    .HLEN       (HLEN),
    .VLEN       (VLEN),
    .LOCK_FRAMES(LOCK_FRAMES),
    .VS_POL     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vid)
  );

  always @(negedge clk) begin
    if (vid.o_frame_start === 1'b1) fs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One pixel clock of stimulus; outputs are observed 1 ns after the edge.
  task automatic cycle(input logic de, input logic vs);
    vid.i_de    = de;
    vid.i_vsync = vs;
    vid.i_hsync = ~de;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int w, input int line_idx, input bit chk);
    for (int i = 0; i < w; i++) begin
      cycle(1'b1, 1'b0);
      if (chk) begin
        check("o_de", 32'(vid.o_de), 1);
        check("hcount", 32'(vid.o_hcount), i);
        check("vcount", 32'(vid.o_vcount), line_idx);
      end
    end
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  task automatic send_frame(input int w, input int h, input bit chk);
    int fs0;
    fs0 = fs_cnt;
    for (int l = 0; l < h; l++) send_line(w, l, chk);
    if (chk) check("frame_start_once", fs_cnt - fs0, 1);
  endtask

  task automatic do_vsync();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic clean_frames(input int n);
    for (int f = 0; f < n; f++) begin
      send_frame(8, 4, 1'b0);
      do_vsync();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    vid.i_de    = 1'b0;
    vid.i_vsync = 1'b0;
    vid.i_hsync = 1'b1;

    // Reset state
    repeat (2) cycle(1'b0, 1'b0);
    rst = 1'b0;
    check("rst_de", 32'(vid.o_de), 0);
    check("rst_hsync", 32'(vid.o_hsync), 0);
    check("rst_hcount", 32'(vid.o_hcount), 0);
    check("rst_vcount", 32'(vid.o_vcount), 0);
    check("rst_hactive", 32'(vid.o_hactive), 0);
    check("rst_vactive", 32'(vid.o_vactive), 0);
    check("rst_frame_start", 32'(vid.o_frame_start), 0);
    check("rst_frame_end", 32'(vid.o_frame_end), 0);
    check("rst_locked", 32'(vid.o_locked), 0);
    check("rst_err", 32'(vid.o_err), 0);

    // Steady 8x4 stream: lock one cycle after the third vsync edge
    send_frame(8, 4, 1'b1);
    do_vsync();
    send_frame(8, 4, 1'b1);
    do_vsync();
    check("locked_after_2", 32'(vid.o_locked), 0);
    send_frame(8, 4, 1'b1);
    cycle(1'b0, 1'b1);
    check("frame_end_pulse", 32'(vid.o_frame_end), 1);
    check("locked_at_edge", 32'(vid.o_locked), 0);
    cycle(1'b0, 1'b1);
    check("frame_end_one_cycle", 32'(vid.o_frame_end), 0);
    check("locked_after_edge", 32'(vid.o_locked), 1);
    repeat (2) cycle(1'b0, 1'b0);
    check("hactive_8", 32'(vid.o_hactive), 8);
    check("vactive_4", 32'(vid.o_vactive), 4);

    // Geometry change while locked
    send_frame(6, 4, 1'b1);
    do_vsync();
    check("geo_change_unlock", 32'(vid.o_locked), 0);
    check("geo_change_hold_hactive", 32'(vid.o_hactive), 8);
    send_frame(6, 4, 1'b0);
    do_vsync();
    send_frame(6, 4, 1'b0);
    do_vsync();
    check("relock_6", 32'(vid.o_locked), 1);
    check("hactive_6", 32'(vid.o_hactive), 6);
    check("vactive_6x4", 32'(vid.o_vactive), 4);
    check("no_err_yet", 32'(vid.o_err), 0);

    // Vsync arrives while DE is high on line 3
    for (int l = 0; l < 3; l++) send_line(6, l, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("midline_frame_end", 32'(vid.o_frame_end), 1);
    cycle(1'b1, 1'b1);
    check("midline_reject", 32'(vid.o_locked), 0);
    cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0);
    send_frame(8, 4, 1'b1);
    do_vsync();
    clean_frames(2);
    check("midline_relock", 32'(vid.o_locked), 1);
    check("midline_hactive", 32'(vid.o_hactive), 8);

    // Reset at pixel 5 of line 2 of a locked stream
    send_line(8, 0, 1'b0);
    send_line(8, 1, 1'b0);
    repeat (5) cycle(1'b1, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b0);
    rst = 1'b0;
    check("midrst_de", 32'(vid.o_de), 0);
    check("midrst_hcount", 32'(vid.o_hcount), 0);
    check("midrst_vcount", 32'(vid.o_vcount), 0);
    check("midrst_hactive", 32'(vid.o_hactive), 0);
    check("midrst_vactive", 32'(vid.o_vactive), 0);
    check("midrst_locked", 32'(vid.o_locked), 0);
    check("midrst_err", 32'(vid.o_err), 0);
    check("midrst_frame_end", 32'(vid.o_frame_end), 0);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    send_line(8, 3, 1'b0);
    do_vsync();
    clean_frames(2);
    check("midrst_not_locked_2", 32'(vid.o_locked), 0);
    clean_frames(1);
    check("midrst_relock_3", 32'(vid.o_locked), 1);
    check("midrst_hactive", 32'(vid.o_hactive), 8);

    // Ragged frame: 8,8,7,8
    pulse_reset();
    check("ragged_pre_err", 32'(vid.o_err), 0);
    clean_frames(3);
    check("ragged_pre_lock", 32'(vid.o_locked), 1);
    send_line(8, 0, 1'b0);
    send_line(8, 1, 1'b0);
    send_line(7, 2, 1'b0);
    send_line(8, 3, 1'b0);
    do_vsync();
    check("ragged_unlock", 32'(vid.o_locked), 0);
    check("ragged_err", 32'(vid.o_err), 1);
    clean_frames(2);
    check("ragged_err_sticky", 32'(vid.o_err), 1);
    check("ragged_not_locked_2", 32'(vid.o_locked), 0);
    clean_frames(1);
    check("ragged_relock", 32'(vid.o_locked), 1);
    check("ragged_err_still", 32'(vid.o_err), 1);

    // 20-pixel DE burst overflows HMAX=16
    pulse_reset();
    check("ovf_pre_err", 32'(vid.o_err), 0);
    clean_frames(3);
    check("ovf_pre_lock", 32'(vid.o_locked), 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 15) begin
        check("ovf_hcount_15", 32'(vid.o_hcount), 15);
        check("ovf_err_at_16th", 32'(vid.o_err), 0);
      end
      if (i == 19) begin
        check("ovf_hcount_hold", 32'(vid.o_hcount), 15);
        check("ovf_err", 32'(vid.o_err), 1);
      end
    end
    repeat (3) cycle(1'b0, 1'b0);
    for (int l = 1; l < 4; l++) send_line(8, l, 1'b0);
    do_vsync();
    check("ovf_reject", 32'(vid.o_locked), 0);
    check("ovf_hold_hactive", 32'(vid.o_hactive), 8);
    check("ovf_err_sticky", 32'(vid.o_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
